// File: rtl/toupper_pkg.sv
// Shared ASCII case definitions for the toupper datapath and its buffering stage.
package toupper_pkg;

    localparam logic [7:0]  ASCII_LC_A = 8'h61;
    localparam logic [7:0]  ASCII_LC_Z = 8'h7A;
    localparam int unsigned CASE_BIT   = 5;

    // One FIFO slot: the byte plus its lowercase flag captured at push time.
    typedef struct packed {
        logic       is_lower;
        logic [7:0] data;
    } char_entry_t;

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= ASCII_LC_A) && (c <= ASCII_LC_Z);
    endfunction

endpackage

// File: rtl/case_gate_fifo_if.sv
// Byte-stream handshake: source-side valid/ready in, sink-side valid/ready out.
interface case_gate_fifo_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_is_lower;
    logic       out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_is_lower
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_is_lower
    );

endinterface

// File: rtl/char_fifo_mem.sv
// DEPTH-entry storage for byte+flag slots: synchronous write, asynchronous read.
module char_fifo_mem
    import toupper_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  char_entry_t   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output char_entry_t   o_rdata
);

    char_entry_t r_mem [DEPTH];

    // Cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/case_gate_fifo.sv
// Buffering stage ahead of the toupper converter: byte FIFO with per-entry
// lowercase flag and a saturating count of accepted lowercase bytes.
module case_gate_fifo
    import toupper_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    case_gate_fifo_if.slave  bus,
    output logic [CNT_W-1:0] lower_cnt,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_lower_cnt;

    logic        w_full;
    logic        w_empty;
    logic        w_in_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_wr_en;
    char_entry_t w_wr_entry;
    char_entry_t w_head;

    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_in_ready = !w_full && !rst;
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = !w_empty && bus.out_ready;
    // Flush drops the byte offered in the same cycle, so it is neither stored nor counted.
    assign w_wr_en    = w_push && !flush;

    assign w_wr_entry.data     = bus.in_data;
    assign w_wr_entry.is_lower = is_lower(bus.in_data);

    char_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lower_cnt <= '0;
        end else if (w_wr_en && w_wr_entry.is_lower && (r_lower_cnt != '1)) begin
            r_lower_cnt <= r_lower_cnt + 1'b1;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = !w_empty;
    assign bus.out_data     = w_head.data;
    assign bus.out_is_lower = w_head.is_lower;

    assign lower_cnt = r_lower_cnt;
    assign full      = w_full;
    assign empty     = w_empty;

endmodule

// File: tb/tb_case_gate_fifo.sv
// Directed bench for case_gate_fifo: default instance plus a CNT_W=3 instance for saturation.
module tb_case_gate_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic [15:0] lower_cnt;
    logic        full;
    logic        empty;

    logic        rst_s;
    logic        flush_s;
    logic [2:0]  lower_cnt_s;
    logic        full_s;
    logic        empty_s;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_lower = 0;

    case_gate_fifo_if bus ();
    case_gate_fifo_if bus_s ();

    case_gate_fifo #(.DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .lower_cnt (lower_cnt),
        .full      (full),
        .empty     (empty)
    );

    case_gate_fifo #(.DEPTH(4), .CNT_W(3)) dut_sat (
        .clk       (clk),
        .rst       (rst_s),
        .flush     (flush_s),
        .bus       (bus_s),
        .lower_cnt (lower_cnt_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    localparam logic [7:0] FILL     [4] = '{8'h61, 8'h5A, 8'h7B, 8'h60};
    localparam logic       FILL_LC  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] STREAM   [3] = '{8'h68, 8'h69, 8'h21};
    localparam logic [7:0] BP_BYTES [6] = '{8'h77, 8'h58, 8'h79, 8'h31, 8'h7A, 8'h2E};
    localparam logic       BP_RDY   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        tick(); tick();
        n_tests++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        n_tests++;
        if (bus.out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got valid=%b empty=%b full=%b expected 0 1 0", bus.out_valid, empty, full);
        end
        n_tests++;
        if (bus.out_data !== 8'h00 || bus.out_is_lower !== 1'b0) begin
            n_fail++; $display("FAIL reset_head: got %h/%b expected 00/0", bus.out_data, bus.out_is_lower);
        end
        n_tests++;
        if (lower_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", lower_cnt); end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL idle_after_reset: got valid=%b empty=%b expected 0 1", bus.out_valid, empty);
        end
    endtask

    task automatic test_fill_and_flags();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = FILL[i];
            tick();
        end
        exp_lower += 1;
        bus.in_data = 8'h41;
        #1;
        n_tests++;
        if (full !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: got full=%b in_ready=%b expected 1 0", full, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (full !== 1'b1 || bus.out_data !== 8'h61) begin
            n_fail++; $display("FAIL fifth_rejected: got full=%b head=%h expected 1 61", full, bus.out_data);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== FILL[i] || bus.out_is_lower !== FILL_LC[i]) begin
                n_fail++; $display("FAIL drain_%0d: got v=%b %h/%b expected 1 %h/%b",
                                   i, bus.out_valid, bus.out_data, bus.out_is_lower, FILL[i], FILL_LC[i]);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_tests++;
        if (empty !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: got empty=%b valid=%b expected 1 0", empty, bus.out_valid);
        end
        n_tests++;
        if (lower_cnt !== 16'(exp_lower)) begin n_fail++; $display("FAIL fill_cnt: got %0d expected %0d", lower_cnt, exp_lower); end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = STREAM[0];
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got valid=%b expected 0", bus.out_valid); end
        tick();
        for (int i = 1; i < 4; i++) begin
            if (i < 3) bus.in_data = STREAM[i];
            else bus.in_valid = 1'b0;
            #1;
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== STREAM[i-1]) begin
                n_fail++; $display("FAIL stream_%0d: got v=%b %h expected 1 %h", i-1, bus.out_valid, bus.out_data, STREAM[i-1]);
            end
            tick();
        end
        exp_lower += 2;
        // A single pop with no push empties the FIFO, so occupancy was 1.
        n_tests++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL stream_occupancy: got empty=%b expected 1", empty); end
        n_tests++;
        if (lower_cnt !== 16'(exp_lower)) begin n_fail++; $display("FAIL stream_cnt: got %0d expected %0d", lower_cnt, exp_lower); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        logic do_push, do_pop;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid  = (c < 6);
            bus.in_data   = (c < 6) ? BP_BYTES[c] : 8'h00;
            bus.out_ready = (c < 6) ? BP_RDY[c] : 1'b1;
            #1;
            n_tests++;
            if (bus.in_ready !== (q.size() < 4) || bus.out_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL bp_flags_c%0d: got rdy=%b v=%b expected %b %b",
                                   c, bus.in_ready, bus.out_valid, q.size() < 4, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_tests++;
                if (bus.out_data !== q[0]) begin
                    n_fail++; $display("FAIL bp_head_c%0d: got %h expected %h", c, bus.out_data, q[0]);
                end
            end
            do_pop  = bus.out_ready && (q.size() != 0);
            do_push = bus.in_valid && (q.size() < 4);
            tick();
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(bus.in_data);
        end
        exp_lower += 3;
        n_tests++;
        if (empty !== 1'b1 || q.size() != 0) begin n_fail++; $display("FAIL bp_end_empty: got empty=%b expected 1", empty); end
        n_tests++;
        if (lower_cnt !== 16'(exp_lower)) begin n_fail++; $display("FAIL bp_cnt: got %0d expected %0d", lower_cnt, exp_lower); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h41; tick();
        bus.in_data = 8'h62; tick();
        bus.in_data = 8'h43; tick();
        exp_lower += 1;
        flush = 1'b1; bus.in_data = 8'h71;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        n_tests++;
        if (empty !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty: got empty=%b valid=%b expected 1 0", empty, bus.out_valid);
        end
        n_tests++;
        if (lower_cnt !== 16'(exp_lower)) begin n_fail++; $display("FAIL flush_cnt: got %0d expected %0d", lower_cnt, exp_lower); end
        bus.in_valid = 1'b1; bus.in_data = 8'h44;
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.out_data !== 8'h44 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL post_flush_head: got v=%b %h expected 1 44", bus.out_valid, bus.out_data);
        end
        tick();
        n_tests++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL post_flush_drain: got empty=%b expected 1", empty); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        int e;
        rst_s = 1'b1; flush_s = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.in_data = 8'h00; bus_s.out_ready = 1'b1;
        tick();
        rst_s = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            bus_s.in_valid = 1'b1; bus_s.in_data = 8'(8'h60 + k);
            tick();
            e = (k > 7) ? 7 : k;
            if (k >= 6) begin
                n_tests++;
                if (lower_cnt_s !== 3'(e)) begin n_fail++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", k, lower_cnt_s, e); end
            end
        end
        rst_s = 1'b1;
        #1;
        n_tests++;
        if (bus_s.in_ready !== 1'b0) begin n_fail++; $display("FAIL sat_rst_ready: got %b expected 0", bus_s.in_ready); end
        tick();
        n_tests++;
        if (lower_cnt_s !== 3'd0 || empty_s !== 1'b1 || bus_s.out_valid !== 1'b0 || bus_s.out_data !== 8'h00) begin
            n_fail++; $display("FAIL sat_mid_reset: got cnt=%0d empty=%b v=%b d=%h expected 0 1 0 00",
                               lower_cnt_s, empty_s, bus_s.out_valid, bus_s.out_data);
        end
        rst_s = 1'b0; bus_s.in_valid = 1'b0;
        tick();
        n_tests++;
        if (empty_s !== 1'b1 || lower_cnt_s !== 3'd0) begin
            n_fail++; $display("FAIL sat_after_reset: got empty=%b cnt=%0d expected 1 0", empty_s, lower_cnt_s);
        end
    endtask

    initial begin
        rst_s = 1'b1; flush_s = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.in_data = 8'h00; bus_s.out_ready = 1'b0;
        test_reset();
        test_fill_and_flags();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/case_gate_fifo.md
Name: case_gate_fifo

Overview:
- Upstream buffering stage for the toupper converter.
- Accepts an ASCII byte stream on a valid/ready handshake and holds up to DEPTH characters.
- Presents the head byte to the converter together with a lowercase flag. The converter only clears bit 5 for 'a'..'z', so punctuation, digits and control characters pass unmodified.
- Keeps a saturating count of accepted lowercase characters for status readout.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
CNT_W, 16, width of the lowercase counter

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  source has a byte on in_data
in_data  in  8  ASCII byte from source
in_ready  out  1  stage can accept a byte this cycle
flush  in  1  synchronous clear of buffered data (counter kept)
out_valid  out  1  head byte is valid
out_data  out  8  head byte, feeds the converter's i7..i0
out_is_lower  out  1  head byte is in 8'h61..8'h7A
out_ready  in  1  converter/sink accepts head byte
lower_cnt  out  CNT_W  accepted lowercase bytes, saturating
full  out  1  DEPTH entries occupied
empty  out  1  zero entries occupied

Behaviour:
- Reset (rst=1 at a clock edge):
  - Write pointer, read pointer and occupancy go to 0; lower_cnt goes to 0.
  - Outputs after reset: out_valid=0, empty=1, full=0, out_data=8'h00, out_is_lower=0.
  - in_ready=0 while rst is high and 1 in the first cycle after it drops.
  - Reset in the middle of traffic discards all entries; no partial handshake survives.
- Push occurs when in_valid && in_ready. in_ready = !full && !rst; it is combinational and does not depend on out_ready.
- Pop occurs when out_valid && out_ready. out_valid = !empty.
- Latency: a byte accepted at edge N appears on out_data with out_valid=1 after edge N. There is no same-cycle bypass.
- Lowercase flag:
  - Computed at push time as (in_data >= 8'h61 && in_data <= 8'h7A) and stored alongside the byte. out_is_lower is registered with the entry.
  - Boundary values: 8'h60 ('`') and 8'h7B ('{') give 0. 8'h61 and 8'h7A give 1. Bytes with bit 7 set give 0.
- lower_cnt:
  - Increments by 1 on each push with the flag set.
  - Saturates at all-ones, with no wrap.
  - Unaffected by flush; cleared only by rst.
- Occupancy and pointers:
  - Push only: occupancy +1. Pop only: occupancy -1.
  - Push and pop in the same cycle (possible only when 0 < occupancy < DEPTH): occupancy unchanged and both pointers advance.
  - When full, in_ready=0, so no push happens even if a pop occurs that cycle. There is no full-bypass.
  - Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Occupancy is log2(DEPTH)+1 bits wide.
- flush:
  - Takes priority over push and pop in the same cycle. Pointers and occupancy go to 0, out_valid=0 next cycle, and any byte presented that cycle is dropped and not counted.
  - rst takes priority over flush.
- out_data and out_is_lower must hold stable while out_valid=1 and out_ready=0.
- Held data while empty:
  - After a flush or the final pop, out_data and out_is_lower may keep the last stored entry, but the sink must ignore them.
  - After rst, they are 0.

Decomposition:
- Shared package toupper_pkg holds:
  - ASCII_LC_A=8'h61, ASCII_LC_Z=8'h7A
  - CASE_BIT=5, the bit the converter clears
  - function is_lower(byte), used here and by any downstream checker
- One sub-module, char_fifo_mem: a DEPTH x 9 register array (byte plus flag) with synchronous write and asynchronous read at the read pointer.
- Pointer and occupancy control, the flag compare and the counter stay in case_gate_fifo.

Test Plan:
- Reset then idle: hold rst 2 cycles -> out_valid=0, empty=1, in_ready=0 during rst and 1 after, lower_cnt=0.
- Push 'a','Z','{','`' (8'h61,8'h5A,8'h7B,8'h60) with out_ready=0:
  - full=1 after the 4th push; in_ready=0; a 5th byte is not accepted.
  - Draining gives out_is_lower 1,0,0,0 in order; lower_cnt=1.
- Streaming at one byte per cycle with out_ready=1 throughout, bytes "hi!" -> output order h,i,! with 1-cycle latency; occupancy never exceeds 1; lower_cnt=2.
- Backpressure: fill 2 entries, toggle out_ready 1,0,1, push every cycle -> no loss or duplication; out_data stable while stalled; order preserved across pointer wrap after 6 total bytes.
- flush asserted with in_valid=1, in_data=8'h71 and 3 entries stored -> empty=1 next cycle; 8'h71 is not stored; lower_cnt unchanged.
- Saturation, with CNT_W overridden to 3: push 9 lowercase bytes -> lower_cnt=7 and held; rst mid-stream -> lower_cnt=0 and empty=1 next cycle.
